alu_issue_seq: RTL

Sequencer stage directly upstream of the 4-bit ALU. It accepts instruction words (operandA, operandB, operation) over a valid/ready handshake and buffers them in a small FIFO. It issues each instruction to the combinational ALU from registered outputs, then captures the 8-bit result and zeroFlag into an output register held under a valid/ready handshake. This turns the ALU into a pipelined, back-pressurable unit for the datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_instr_fifo.sv | 50 +++++
 rtl/alu_issue_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: operand/result widths,
// opcode constants, the buffered instruction format and the sequencer states.
package alu_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef struct packed {
    logic [OPW-1:0] opa;
    logic [OPW-1:0] opb;
    logic [2:0]     op;
  } alu_instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_t;

  // Opcodes 101, 110 and 111 have no ALU function behind them.
  function automatic logic alu_op_legal(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// Instruction FIFO feeding the issue sequencer. Pointers carry one extra
// bit so that full and empty can be told apart when the indices match.
module alu_instr_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  alu_instr_t             wdata,
  input  logic                   pop,
  output alu_instr_t             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;
  alu_instr_t  mem [DEPTH];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Advance the write/read pointers on accepted pushes and pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer in front of the combinational ALU: buffers instructions,
// drives the ALU from registers for a full cycle, then holds the captured
// result under a valid/ready handshake.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         in_opa,
  input  logic [OPW-1:0]         in_opb,
  input  logic [2:0]             in_op,
  output logic [OPW-1:0]         alu_operandA,
  output logic [OPW-1:0]         alu_operandB,
  output logic [2:0]             alu_operation,
  input  logic [RESW-1:0]        alu_result,
  input  logic                   alu_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RESW-1:0]        out_result,
  output logic                   out_zero,
  output logic [2:0]             out_op,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  seq_state_t state_q;
  seq_state_t state_d;
  alu_instr_t push_data;
  alu_instr_t head;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       capture;
  logic       out_clear;

  // Readiness never anticipates a same-cycle pop, so a full FIFO always refuses.
  assign in_ready  = !fifo_full && !rst;
  assign fifo_push = in_valid && in_ready;
  assign push_data = '{opa: in_opa, opb: in_opb, op: in_op};

  alu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the pop, capture and release strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    out_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_clear = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive registers load only on a pop and otherwise keep their value.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_operandA  <= '0;
      alu_operandB  <= '0;
      alu_operation <= '0;
    end else if (fifo_pop) begin
      alu_operandA  <= head.opa;
      alu_operandB  <= head.opb;
      alu_operation <= head.op;
    end
  end

  // Result register: capture after the issue cycle, frozen until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_op     <= '0;
      out_err    <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_op    <= alu_operation;
      if (alu_op_legal(alu_operation)) begin
        out_result <= alu_result;
        out_zero   <= alu_zero;
        out_err    <= 1'b0;
      end else begin
        out_result <= '0;
        out_zero   <= 1'b0;
        out_err    <= 1'b1;
      end
    end else if (out_clear) begin
      out_valid <= 1'b0;
    end
  end

endmodule
